// File: rtl/ahb_const_pkg.sv
// AHB-Lite constants, FSM state encoding and byte-lane helpers shared by the
// native-memory AHB slave and its lane steering block.
package ahb_const_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WDAT = 3'd1,
    ST_MEM  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } state_t;

  // Per-transfer info that must survive into the data phase.
  typedef struct packed {
    logic       write;
    logic [3:0] strb;
  } xfer_t;

  function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = lane[0];
      HSIZE_WORD: bad = (lane != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << lane;
      HSIZE_HALF: s = lane[1] ? 4'b1100 : 4'b0011;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Maps a 32-bit word between AHB byte order and little-endian native order.
// The mapping is its own inverse, so one block serves both directions.
module ahb_lane_steer #(
  parameter int BIG_ENDIAN_AHB = 1
) (
  input  logic [31:0] i_dat,
  output logic [31:0] o_dat
);

  if (BIG_ENDIAN_AHB != 0) begin : g_swap
    assign o_dat = {i_dat[7:0], i_dat[15:8], i_dat[23:16], i_dat[31:24]};
  end else begin : g_straight
    assign o_dat = i_dat;
  end

endmodule

// File: rtl/native_mem_ahb_slave.sv
// AHB-Lite slave that issues one PicoRV32-style native memory request per
// accepted transfer; reads complete with registered, lane-steered HRDATA.
module native_mem_ahb_slave
  import ahb_const_pkg::*;
#(
  parameter int BIG_ENDIAN_AHB = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [3:0]  i_hprot,
  input  logic [31:0] i_hwdata,
  input  logic        i_hready,
  output logic        o_hreadyout,
  output logic [1:0]  o_hresp,
  output logic [31:0] o_hrdata,
  output logic        o_mem_valid,
  output logic        o_mem_instr,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  xfer_t         r_xfer;
  logic [TW-1:0] r_timer;
  logic          r_mem_valid;
  logic          r_mem_instr;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic [31:0]   r_hrdata;

  logic          w_active;
  logic          w_accept;
  logic          w_illegal;
  logic          w_mem_done;
  logic          w_timeout;
  logic [31:0]   w_wdata_le;
  logic [31:0]   w_rdata_ahb;
  logic          w_unused;

  assign w_unused = ^i_hprot[3:1];

  ahb_lane_steer #(.BIG_ENDIAN_AHB(BIG_ENDIAN_AHB)) u_wsteer (
    .i_dat (i_hwdata),
    .o_dat (w_wdata_le)
  );

  ahb_lane_steer #(.BIG_ENDIAN_AHB(BIG_ENDIAN_AHB)) u_rsteer (
    .i_dat (i_mem_rdata),
    .o_dat (w_rdata_ahb)
  );

  // SEQ carries no burst meaning here; it is treated exactly like NONSEQ.
  assign w_active   = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
  assign w_accept   = i_hsel && i_hready && w_active &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_illegal  = size_illegal(i_hsize, i_haddr[1:0]);
  assign w_mem_done = (r_state == ST_MEM) && i_mem_ready;

  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    assign w_timeout = (r_state == ST_MEM) && !i_mem_ready &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_tmo
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (!w_accept) begin
          w_state_nxt = ST_IDLE;
        end else if (w_illegal) begin
          w_state_nxt = ST_ERR1;
        end else begin
          w_state_nxt = i_hwrite ? ST_WDAT : ST_MEM;
        end
      end
      ST_WDAT: begin
        o_hreadyout = 1'b0;
        w_state_nxt = ST_MEM;
      end
      ST_MEM: begin
        o_hreadyout = 1'b0;
        if (w_mem_done) begin
          w_state_nxt = ST_DONE;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        o_hresp     = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_xfer      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_hrdata    <= '0;
    end else begin
      if (w_accept && !w_illegal) begin
        r_xfer.write <= i_hwrite;
        r_xfer.strb  <= lane_strb(i_hsize, i_haddr[1:0]);
        r_mem_addr   <= {i_haddr[31:2], 2'b00};
        r_mem_instr  <= ~i_hprot[0];
        r_mem_wstrb  <= 4'b0000;
        r_mem_valid  <= ~i_hwrite;
      end
      // Write data only exists in the first data-phase cycle.
      if (r_state == ST_WDAT) begin
        r_mem_wdata <= w_wdata_le & strb_mask(r_xfer.strb);
        r_mem_wstrb <= r_xfer.strb;
        r_mem_valid <= 1'b1;
      end
      if (w_mem_done) begin
        r_mem_valid <= 1'b0;
        r_mem_wstrb <= 4'b0000;
        if (!r_xfer.write) begin
          r_hrdata <= w_rdata_ahb;
        end
      end else if (w_timeout) begin
        r_mem_valid <= 1'b0;
        r_mem_wstrb <= 4'b0000;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (r_state == ST_MEM) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  assign o_hrdata    = r_hrdata;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_instr = r_mem_instr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_native_mem_ahb_slave.sv
// Bench for native_mem_ahb_slave (big-endian AHB, 8-cycle timeout): native
// requests and read data are checked against scoreboard queues.
module tb_native_mem_ahb_slave;
  import ahb_const_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        write;
    logic        instr;
  } req_t;

  logic        clk;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int n_req    = 0;
  req_t        exp_req[$];
  logic [31:0] exp_rd[$];

  native_mem_ahb_slave #(.BIG_ENDIAN_AHB(1), .TIMEOUT_CYCLES(8)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_hsel      (hsel),
    .i_haddr     (haddr),
    .i_htrans    (htrans),
    .i_hwrite    (hwrite),
    .i_hsize     (hsize),
    .i_hprot     (hprot),
    .i_hwdata    (hwdata),
    .i_hready    (hready),
    .o_hreadyout (hreadyout),
    .o_hresp     (hresp),
    .o_hrdata    (hrdata),
    .o_mem_valid (mem_valid),
    .o_mem_instr (mem_instr),
    .i_mem_ready (mem_ready),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wstrb (mem_wstrb),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every new native request is popped from the scoreboard as it appears.
  always begin : mon
    req_t r;
    @(posedge mem_valid);
    #1;
    n_checks++;
    if (exp_req.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_req: got addr=%h wstrb=%b, no request expected", mem_addr, mem_wstrb);
    end else begin
      r = exp_req.pop_front();
      n_req++;
      if (mem_addr !== r.addr || mem_wstrb !== r.wstrb || mem_instr !== r.instr ||
          (r.write && mem_wdata !== r.wdata)) begin
        n_errors++;
        $display("FAIL native_req: got addr=%h wstrb=%b wdata=%h instr=%b, want addr=%h wstrb=%b wdata=%h instr=%b",
                 mem_addr, mem_wstrb, mem_wdata, mem_instr, r.addr, r.wstrb, r.wdata, r.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [3:0] prot);
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    hprot  = prot;
  endtask

  // Runs a data phase as the native memory: mem_ready after 'waits' cycles of mem_valid.
  task automatic run_data(input logic [31:0] wd, input int waits, input logic [31:0] rd,
                          output int cycles);
    int seen;
    seen   = 0;
    cycles = 0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (cycles == 1) begin
        idle_bus();
        hwdata = wd;
      end
      mem_ready = 1'b0;
      if (hreadyout) break;
      if (mem_valid) begin
        if (seen == waits) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end
        seen++;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) tick();
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0 || mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_bus: got rdy=%b resp=%b rdata=%h valid=%b, want 1 00 0 0",
               hreadyout, hresp, hrdata, mem_valid);
    end
    n_checks++;
    if (mem_instr !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_native: got instr=%b addr=%h wdata=%h wstrb=%b, want all zero",
               mem_instr, mem_addr, mem_wdata, mem_wstrb);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (hreadyout !== 1'b1 || mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset_idle: got rdy=%b valid=%b, want 1 0", hreadyout, mem_valid);
    end
  endtask

  task automatic test_word_read;
    int cyc;
    logic [31:0] e;
    drive_addr(1'b0, HSIZE_WORD, 32'h4000_0008, 4'b0011);
    exp_req.push_back('{addr: 32'h4000_0008, wstrb: 4'b0000, wdata: 32'h0, write: 1'b0, instr: 1'b0});
    exp_rd.push_back(32'h1122_3344);
    run_data(32'h0, 2, 32'h4433_2211, cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_errors++;
      $display("FAIL read_latency: got %0d data-phase cycles, want 4", cyc);
    end
    e = exp_rd.pop_front();
    n_checks++;
    if (hrdata !== e || hresp !== HRESP_OKAY) begin
      n_errors++;
      $display("FAIL read_data: got hrdata=%h resp=%b, want %h 00", hrdata, hresp, e);
    end
  endtask

  task automatic test_byte_write;
    int cyc;
    drive_addr(1'b1, HSIZE_BYTE, 32'h2000_0001, 4'b0011);
    exp_req.push_back('{addr: 32'h2000_0000, wstrb: 4'b0010, wdata: 32'h0000_AB00, write: 1'b1, instr: 1'b0});
    run_data(32'h00AB_0000, 0, 32'h0, cyc);
    n_checks++;
    if (cyc !== 3 || hresp !== HRESP_OKAY) begin
      n_errors++;
      $display("FAIL write_latency: got %0d cycles resp=%b, want 3 00", cyc, hresp);
    end
    n_checks++;
    if (mem_wstrb !== 4'b0000 || mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL write_clear: got wstrb=%b valid=%b, want 0000 0", mem_wstrb, mem_valid);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] a_tab [2];
    logic [2:0]  s_tab [2];
    a_tab[0] = 32'h1000_0003; s_tab[0] = HSIZE_HALF;
    a_tab[1] = 32'h1000_0000; s_tab[1] = 3'b011;
    for (int i = 0; i < 2; i++) begin
      drive_addr(1'b0, s_tab[i], a_tab[i], 4'b0011);
      tick();
      idle_bus();
      n_checks++;
      if (hreadyout !== 1'b0 || hresp !== HRESP_ERROR || mem_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL err1[%0d]: got rdy=%b resp=%b valid=%b, want 0 01 0", i, hreadyout, hresp, mem_valid);
      end
      tick();
      n_checks++;
      if (hreadyout !== 1'b1 || hresp !== HRESP_ERROR || mem_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL err2[%0d]: got rdy=%b resp=%b valid=%b, want 1 01 0", i, hreadyout, hresp, mem_valid);
      end
      tick();
      n_checks++;
      if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY) begin
        n_errors++;
        $display("FAIL err_exit[%0d]: got rdy=%b resp=%b, want 1 00", i, hreadyout, hresp);
      end
    end
  endtask

  task automatic test_timeout;
    int vcyc;
    vcyc = 0;
    drive_addr(1'b0, HSIZE_WORD, 32'h3000_0000, 4'b0011);
    exp_req.push_back('{addr: 32'h3000_0000, wstrb: 4'b0000, wdata: 32'h0, write: 1'b0, instr: 1'b0});
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) idle_bus();
      if (!mem_valid) break;
      vcyc++;
    end
    n_checks++;
    if (vcyc !== 8) begin
      n_errors++;
      $display("FAIL timeout_len: got %0d cycles of mem_valid, want 8", vcyc);
    end
    n_checks++;
    if (hreadyout !== 1'b0 || hresp !== HRESP_ERROR) begin
      n_errors++;
      $display("FAIL timeout_err1: got rdy=%b resp=%b, want 0 01", hreadyout, hresp);
    end
    tick();
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== HRESP_ERROR) begin
      n_errors++;
      $display("FAIL timeout_err2: got rdy=%b resp=%b, want 1 01", hreadyout, hresp);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY || hrdata !== 32'h1122_3344 || mem_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL late_ready: got rdy=%b resp=%b hrdata=%h valid=%b, want 1 00 11223344 0",
               hreadyout, hresp, hrdata, mem_valid);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int n0;
    logic [31:0] e;
    n0 = n_req;
    drive_addr(1'b0, HSIZE_WORD, 32'h5000_0010, 4'b0010);
    exp_req.push_back('{addr: 32'h5000_0010, wstrb: 4'b0000, wdata: 32'h0, write: 1'b0, instr: 1'b1});
    exp_rd.push_back(32'hAABB_CCDD);
    run_data(32'h0, 1, 32'hDDCC_BBAA, cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_errors++;
      $display("FAIL b2b_read_latency: got %0d cycles, want 3", cyc);
    end
    e = exp_rd.pop_front();
    n_checks++;
    if (hrdata !== e) begin
      n_errors++;
      $display("FAIL b2b_read_data: got %h, want %h", hrdata, e);
    end
    // Next address phase overlaps the DONE cycle of the read.
    drive_addr(1'b1, HSIZE_HALF, 32'h5000_0022, 4'b0010);
    exp_req.push_back('{addr: 32'h5000_0020, wstrb: 4'b1100, wdata: 32'h3412_0000, write: 1'b1, instr: 1'b1});
    run_data(32'h0000_1234, 0, 32'h0, cyc);
    n_checks++;
    if (cyc !== 3 || hresp !== HRESP_OKAY || mem_instr !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_write: got %0d cycles resp=%b instr=%b, want 3 00 1", cyc, hresp, mem_instr);
    end
    n_checks++;
    if (n_req - n0 !== 2 || exp_req.size() !== 0) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d requests, %0d pending, want 2 and 0", n_req - n0, exp_req.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [31:0] e;
    drive_addr(1'b0, HSIZE_WORD, 32'h6000_0004, 4'b0011);
    exp_req.push_back('{addr: 32'h6000_0004, wstrb: 4'b0000, wdata: 32'h0, write: 1'b0, instr: 1'b0});
    tick();
    idle_bus();
    n_checks++;
    if (mem_valid !== 1'b1 || hreadyout !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_pre: got valid=%b rdy=%b, want 1 0", mem_valid, hreadyout);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (mem_valid !== 1'b0 || hreadyout !== 1'b1 || hresp !== HRESP_OKAY) begin
      n_errors++;
      $display("FAIL async_reset: got valid=%b rdy=%b resp=%b, want 0 1 00", mem_valid, hreadyout, hresp);
    end
    #1 reset = 1'b0;
    drive_addr(1'b0, HSIZE_WORD, 32'h6000_0008, 4'b0011);
    exp_req.push_back('{addr: 32'h6000_0008, wstrb: 4'b0000, wdata: 32'h0, write: 1'b0, instr: 1'b0});
    exp_rd.push_back(32'h0A0B_0C0D);
    run_data(32'h0, 0, 32'h0D0C_0B0A, cyc);
    e = exp_rd.pop_front();
    n_checks++;
    if (cyc !== 2 || hrdata !== e || hresp !== HRESP_OKAY) begin
      n_errors++;
      $display("FAIL post_reset_read: got %0d cycles hrdata=%h resp=%b, want 2 %h 00", cyc, hrdata, hresp, e);
    end
  endtask

  initial begin
    reset     = 1'b1;
    hsel      = 1'b0;
    haddr     = 32'h0;
    htrans    = HTRANS_IDLE;
    hwrite    = 1'b0;
    hsize     = HSIZE_WORD;
    hprot     = 4'b0011;
    hwdata    = 32'h0;
    hready    = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    test_reset();
    test_word_read();
    test_byte_write();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();

    repeat (2) tick();
    n_checks++;
    if (exp_req.size() !== 0 || n_req !== 7) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d requests, %0d pending, want 7 and 0", n_req, exp_req.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
